dc_block_sched: RTL and testbench

Time-shared, multichannel DC-removal engine with a built-in scheduler. A round-robin arbiter grants one of NUM_CH sample requesters per cycle to a single DC-blocking datapath. Per-channel filter state is held in a register array. Each channel starts with a fast-settle shift, then switches to the long-tau shift after a programmed number of samples. It sits between the per-channel decimator outputs and the downstream audio/sample bus.

---
 rtl/dc_block_sched.sv | 85 ++++++++
 tb/tb_dc_block_sched.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dc_block_sched.sv
// dc_block_sched: round-robin multichannel DC-blocking filter with per-channel fast-settle phase
module dc_block_sched #(
   parameter int WIDTH = 32,
   parameter int NUM_CH = 4,
   parameter int DC_BLOCK_SHIFT = 10,
   parameter int FAST_SHIFT = 4,
   parameter int SETTLE_SAMPLES = 1024,
   localparam int CW = $clog2(NUM_CH),
   localparam int NW = $clog2(SETTLE_SAMPLES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       ch_clear,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [CW-1:0]           out_ch,
   output logic                    out_settled
);
   localparam logic [NW-1:0] SETTLE = NW'(SETTLE_SAMPLES);
   logic signed [WIDTH-1:0] s [NUM_CH];
   logic [NW-1:0] cnt [NUM_CH];
   logic signed [WIDTH-1:0] xs [NUM_CH];
   logic [CW-1:0] ptr, win;
   logic hit, stall, acc, fast;
   logic signed [WIDTH-1:0] s_k, y, s_n;
   logic [NW-1:0] c_k;
   always_comb begin
      for (int j = 0; j < NUM_CH; j++) xs[j] = in_data[j*WIDTH +: WIDTH];
   end
   // descending scan so the requester closest to the pointer is assigned last and wins
   always_comb begin
      win = '0;
      hit = 1'b0;
      for (int j = NUM_CH - 1; j >= 0; j--) begin
         if (in_valid[CW'((int'(ptr) + j) % NUM_CH)]) begin
            win = CW'((int'(ptr) + j) % NUM_CH);
            hit = 1'b1;
         end
      end
   end
   assign stall = out_valid & ~out_ready;
   assign in_ready = (rst | stall | ~hit) ? '0 : NUM_CH'(1) << win;
   assign acc = |in_ready;
   // a same-cycle clear is folded in before the filter update
   assign s_k = ch_clear[win] ? '0 : s[win];
   assign c_k = ch_clear[win] ? '0 : cnt[win];
   assign fast = c_k < SETTLE;
   assign y = xs[win] - s_k;
   assign s_n = s_k + (fast ? y >>> FAST_SHIFT : y >>> DC_BLOCK_SHIFT);
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_ch <= '0;
         out_settled <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            s[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_clear[i]) begin
               s[i] <= '0;
               cnt[i] <= '0;
            end
         end
         if (acc) begin
            s[win] <= s_n;
            cnt[win] <= fast ? c_k + 1'b1 : c_k;
            ptr <= (win == CW'(NUM_CH - 1)) ? '0 : win + 1'b1;
            out_valid <= 1'b1;
            out_data <= y;
            out_ch <= win;
            out_settled <= ~fast;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dc_block_sched.sv
// tb_dc_block_sched: directed bench for dc_block_sched with a per-cycle behavioural model
module tb_dc_block_sched;
   logic clk = 1'b0;
   logic rst;
   logic [3:0] in_valid, in_ready, ch_clear;
   logic [127:0] in_data;
   logic out_valid, out_ready, out_settled;
   logic [31:0] out_data;
   logic [1:0] out_ch;
   int tests = 0;
   int fails = 0;
   logic signed [31:0] ms [4] = '{default: 0};
   int mc [4] = '{default: 0};
   int mp = 0;
   bit mv = 0;
   logic [31:0] md = 0;
   int mch = 0;
   bit mset = 0;
   dc_block_sched #(.WIDTH(32), .NUM_CH(4), .DC_BLOCK_SHIFT(10), .FAST_SHIFT(4), .SETTLE_SAMPLES(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .ch_clear(ch_clear), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .out_settled(out_settled)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input longint a, input longint e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   function automatic int grant_of(input int p, input logic [3:0] v);
      for (int j = 0; j < 4; j++) if (v[2'((p + j) % 4)]) return (p + j) % 4;
      return -1;
   endfunction
   function automatic logic [3:0] exp_ready();
      int g = grant_of(mp, in_valid);
      return (rst || (mv && !out_ready) || g < 0) ? 4'b0 : 4'(1 << g);
   endfunction
   task automatic step();
      logic [3:0] er = exp_ready();
      int k = grant_of(mp, in_valid);
      logic signed [31:0] x, yy;
      int sh;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin ms[i] = 0; mc[i] = 0; end
         mp = 0; mv = 0; md = 0; mch = 0; mset = 0;
      end else begin
         for (int i = 0; i < 4; i++) if (ch_clear[i]) begin ms[i] = 0; mc[i] = 0; end
         if (er != 0) begin
            x = in_data[k*32 +: 32];
            sh = (mc[k] < 8) ? 4 : 10;
            yy = x - ms[k];
            ms[k] = ms[k] + (yy >>> sh);
            mc[k] = (mc[k] < 8) ? mc[k] + 1 : 8;
            mp = (k + 1) % 4;
            mv = 1; md = yy; mch = k; mset = (sh == 10);
         end else if (out_ready) begin
            mv = 0;
         end
      end
   endtask
   task automatic cyc(input bit ck = 1);
      @(negedge clk);
      if (ck) begin
         chk("in_ready", in_ready, exp_ready());
         chk("out_valid", out_valid, mv);
         chk("out_data", $signed(out_data), $signed(md));
         chk("out_ch", out_ch, mch);
         chk("out_settled", out_settled, mset);
      end
      @(posedge clk);
      step();
      #1;
   endtask
   task automatic setd(input int c, input int v);
      in_data[c*32 +: 32] = v;
   endtask
   initial begin
      rst = 1; in_valid = 0; in_data = 0; ch_clear = 0; out_ready = 1;
      cyc(0);
      cyc();
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst in_ready", in_ready, 0);
      rst = 0;
      in_valid = 4'b0001; setd(0, 1000);
      cyc(); chk("step y1", $signed(out_data), 1000); chk("step s1", ms[0], 62);
      cyc(); chk("step y2", $signed(out_data), 938); chk("step s2", ms[0], 120);
      cyc(); chk("step y3", $signed(out_data), 880); chk("step s3", ms[0], 175);
      in_valid = 0;
      cyc(); chk("step idle", out_valid, 0);
      rst = 1; cyc(); rst = 0;
      in_valid = 4'b1111;
      for (int c = 0; c < 4; c++) setd(c, 100 * (c + 1));
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rr out_ch", out_ch, i % 4);
         if (i < 4) chk("rr out_data", $signed(out_data), 100 * (i + 1));
      end
      out_ready = 0; #1;
      chk("stall in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         ch_clear = (i == 1) ? 4'b0001 : 4'b0000;
         cyc();
         chk("stall out_ch", out_ch, 3);
         chk("stall out_valid", out_valid, 1);
      end
      ch_clear = 0; out_ready = 1; #1;
      chk("resume in_ready", in_ready, 4'b0001);
      cyc();
      chk("resume out_ch", out_ch, 0);
      chk("resume cleared y", $signed(out_data), 100);
      in_valid = 0; cyc();
      rst = 1; cyc(); rst = 0;
      in_valid = 4'b0010; setd(1, 500);
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("settle flag", out_settled, i == 8);
         chk("settle out_ch", out_ch, 1);
      end
      in_valid = 4'b0100; setd(2, 300);
      cyc(); cyc();
      ch_clear = 4'b0100; setd(2, -1000);
      cyc();
      chk("clr y", $signed(out_data), -1000);
      chk("clr settled", out_settled, 0);
      chk("clr s", ms[2], -63);
      chk("clr cnt", mc[2], 1);
      ch_clear = 0; in_valid = 0; cyc();
      for (int i = 0; i < 60; i++) begin
         in_valid = 4'(i * 7 + 3);
         out_ready = (i % 3 != 0);
         ch_clear = (i % 9 == 4) ? 4'(1 << (i % 4)) : 4'b0;
         for (int c = 0; c < 4; c++) setd(c, i * 40503 - c * 977123 + c * 700000000);
         cyc();
      end
      ch_clear = 0; in_valid = 4'b1111; out_ready = 1;
      cyc();
      chk("pre-rst out_valid", out_valid, 1);
      rst = 1; in_valid = 4'b1010; setd(1, 777); setd(3, 555); #1;
      chk("rst in_ready", in_ready, 0);
      cyc();
      chk("rst drop", out_valid, 0);
      rst = 0;
      cyc();
      chk("post-rst ch", out_ch, 1);
      chk("post-rst y", $signed(out_data), 777);
      in_valid = 0;
      cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
